// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request arbiter and its arbitration helper.
package alu_pkg;
    localparam int ALU_OP_W = 4;
    localparam int FLAG_W   = 6;
    localparam int FLG_Z    = 5;
    localparam int FLG_C    = 4;
    localparam int FLG_O    = 3;
    localparam int FLG_G    = 2;
    localparam int FLG_L    = 1;
    localparam int FLG_E    = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;
endpackage

// File: rtl/alu_req_arbiter_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins; on a tie the one not served last wins.
// Purely combinational; the caller owns the last-grant register.
module rr_arb2 (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_any_valid
);
    assign o_grant     = (i_valid0 & i_valid1) ? ~i_last_grant : i_valid1;
    assign o_any_valid = i_valid0 | i_valid1;
endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: grant, hold operands ALU_LAT+1 edges, return result with id.
// One op in flight; requesters stall (ready low) until the response is consumed.
module alu_req_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [WIDTH-1:0]    req0_a,
    input  logic [WIDTH-1:0]    req0_b,
    input  logic [ALU_OP_W-1:0] req0_op,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [WIDTH-1:0]    req1_a,
    input  logic [WIDTH-1:0]    req1_b,
    input  logic [ALU_OP_W-1:0] req1_op,
    output logic [WIDTH-1:0]    alu_a,
    output logic [WIDTH-1:0]    alu_b,
    output logic [ALU_OP_W-1:0] alu_s,
    input  logic [WIDTH-1:0]    alu_f,
    input  logic [FLAG_W-1:0]   alu_flags,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [WIDTH-1:0]    rsp_f,
    output logic [FLAG_W-1:0]   rsp_flags,
    output logic                busy
);
    localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

    state_t              r_state;
    state_t              w_next_state;
    logic [2:0]          r_cnt;
    logic                r_last_grant;
    logic [WIDTH-1:0]    r_alu_a;
    logic [WIDTH-1:0]    r_alu_b;
    logic [ALU_OP_W-1:0] r_alu_s;
    logic [WIDTH-1:0]    r_rsp_f;
    logic [FLAG_W-1:0]   r_rsp_flags;
    logic                r_rsp_id;
    logic                w_grant;
    logic                w_any_valid;
    logic                w_hs;

    rr_arb2 u_arb (
        .i_valid0     (req0_valid),
        .i_valid1     (req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_any_valid  (w_any_valid)
    );

    // rst gates ready directly so a held reset never lets a handshake through
    assign w_hs       = (r_state == IDLE) & ~rst & w_any_valid;
    assign req0_ready = w_hs & ~w_grant;
    assign req1_ready = w_hs & w_grant;

    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_s     = r_alu_s;
    assign rsp_f     = r_rsp_f;
    assign rsp_flags = r_rsp_flags;
    assign rsp_id    = r_rsp_id;
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next_state = WAIT;
            WAIT:    if (r_cnt == 3'd0) w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_s      <= '0;
            r_rsp_f      <= '0;
            r_rsp_flags  <= '0;
            r_rsp_id     <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_alu_a      <= w_grant ? req1_a  : req0_a;
                        r_alu_b      <= w_grant ? req1_b  : req0_b;
                        r_alu_s      <= w_grant ? req1_op : req0_op;
                        r_last_grant <= w_grant;
                        r_cnt        <= LAT_LOAD;
                    end
                end
                WAIT: begin
                    if (r_cnt == 3'd0) begin
                        r_rsp_f     <= alu_f;
                        r_rsp_flags <= alu_flags;
                        r_rsp_id    <= r_last_grant;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
- Shares one ALU datapath (8-bit operands A/B, 4-bit select S3..S0, result F, flags z,c,o,G,L,E) between two requesters.
- Each requester issues an operation over a valid/ready handshake. The block round-robin arbitrates, drives and holds the ALU inputs for the ALU latency, captures F and the flags, and returns them with a requester ID over a valid/ready response channel.
- Sits between the command sources and the ALU top; at most one operation is in flight.

Parameters:
WIDTH, 8, operand/result width
ALU_LAT, 1, clock edges from the ALU inputs changing to alu_f/alu_flags being valid (0 = combinational ALU); legal range 0..7

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0_valid  in  1  requester 0 has an op
req0_ready  out  1  requester 0 op accepted this cycle
req0_a  in  WIDTH  operand A
req0_b  in  WIDTH  operand B
req0_op  in  4  ALU select {S3,S2,S1,S0}
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0
alu_a  out  WIDTH  to ALU A
alu_b  out  WIDTH  to ALU B
alu_s  out  4  to ALU {S3,S2,S1,S0}
alu_f  in  WIDTH  ALU result F
alu_flags  in  6  {z,c,o,G,L,E}
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  1  requester that issued the op
rsp_f  out  WIDTH  captured F
rsp_flags  out  6  captured {z,c,o,G,L,E}
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync-safe release): state=IDLE; alu_a, alu_b, alu_s, rsp_f, rsp_flags = 0; rsp_valid, rsp_id, busy, req*_ready = 0; last_grant=1, so requester 0 wins first.
- FSM IDLE -> WAIT -> RESP -> IDLE.
- IDLE:
  - grant = the single valid requester; if both are valid, the one != last_grant.
  - reqN_ready = (state==IDLE) & grant==N, combinational. The handshake is valid&ready.
  - On the handshake edge: register a/b/op into alu_a/alu_b/alu_s, set last_grant=N, load cnt=ALU_LAT, go to WAIT.
- WAIT:
  - alu_a/alu_b/alu_s held stable.
  - cnt decrements each edge. On the edge where cnt==0: capture alu_f into rsp_f and alu_flags into rsp_flags, set rsp_id=last_grant and rsp_valid=1, go to RESP.
  - Timing: handshake at edge N gives rsp_valid high from edge N+ALU_LAT+1.
- RESP:
  - rsp_* held stable while rsp_valid & !rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0, go to IDLE.
  - There is no same-cycle re-grant. The next grant happens at the earliest on the cycle after returning to IDLE.
  - Minimum issue interval is ALU_LAT+3 cycles.
- req*_ready is 0 in WAIT and RESP. Requesters hold valid and fields until ready. Valid may drop without a handshake; it is sampled only in IDLE.
- All 16 op codes pass through unmodified; the block does no op decoding.
- alu_a/b/s keep the last op's values after completion (no return to 0) until the next grant.
- Reset mid-WAIT or mid-RESP aborts the op. The response is discarded and all outputs return to reset values immediately.
- rst held high: the ready outputs stay 0 regardless of valid.

Decomposition:
- Package alu_pkg: ALU_OP_W=4, FLAG_W=6, flag indices FLG_Z=5, FLG_C=4, FLG_O=3, FLG_G=2, FLG_L=1, FLG_E=0, state enum {IDLE, WAIT, RESP}.
- Sub-module rr_arb2: 2-way round-robin grant from (valid0, valid1, last_grant) -> grant, any_valid. Purely combinational; last_grant is registered in the parent.

Test Plan:
Bench ALU model: registered with latency ALU_LAT=1; F=(A+B) mod 256, flags={F==0, carry, 4'b0}.
- Reset: rst=1 asynchronously during WAIT -> same delta: rsp_valid=0, alu_a=0, alu_s=0, busy=0; first grant after release goes to req0.
- Single op: req0 A=8'h55 B=8'h7F op=4'b0000, rsp_ready=1, handshake at edge N -> alu_a=8'h55 from N; rsp_valid=1 from N+2 with rsp_f=8'hD4, rsp_flags=6'b000000, rsp_id=0.
- Carry/zero: req1 A=8'hFF B=8'h01 op=4'b1111 -> alu_s=4'b1111; rsp_f=8'h00, rsp_flags=6'b110000, rsp_id=1.
- Simultaneous after reset: both valid (req0 A=8'h01, req1 A=8'h02, B=0) -> responses in order rsp_id 0 then 1; then req0 is granted again if both stay valid (alternating 0,1,0,1 over 4 ops).
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_f, rsp_flags stable; req0_ready=req1_ready=0; alu_a unchanged; release -> IDLE next cycle.
- Latency sweep: ALU_LAT=0 and 3 -> rsp_valid at handshake edge +1 and +4 respectively, correct F captured.
